// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state, one-hot result, gt/lt swap helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t RES_EQ   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    localparam cmp_res_t RES_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

    // A two's-complement sign bit ranks opposite to a magnitude bit.
    function automatic cmp_res_t swap_gt_lt(input cmp_res_t r);
        return '{gt: r.lt, eq: r.eq, lt: r.gt};
    endfunction

endpackage

// File: rtl/bit_cmp.sv
// Combinational 1-bit magnitude compare cell.
module bit_cmp (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = a & ~b;
    assign eq = ~(a ^ b);
    assign lt = ~a & b;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial WIDTH-bit comparator, MSB first, one bit_cmp cell reused per clock.
// Optional macro CMP_EARLY_EXIT_EN: leave SCAN on the first differing bit.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    cmp_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             found_q, found_d;
    cmp_res_t         sticky_q, sticky_d;
    cmp_res_t         res_q, res_d;
    logic             out_valid_q, out_valid_d;

    logic     cell_gt, cell_eq, cell_lt;
    cmp_res_t cell_res, bit_res;
    logic     diff_now, scan_last;

    bit_cmp u_bit_cmp (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .gt (cell_gt),
        .eq (cell_eq),
        .lt (cell_lt)
    );

    assign cell_res = '{gt: cell_gt, eq: cell_eq, lt: cell_lt};
    assign bit_res  = (SIGNED_CMP && (idx_q == IDX_MSB)) ? swap_gt_lt(cell_res) : cell_res;
    assign diff_now = ~cell_eq;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        found_d     = found_q;
        sticky_d    = sticky_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        scan_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = IDX_MSB;
                    found_d  = 1'b0;
                    sticky_d = RES_NONE;
                    res_d    = RES_NONE;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // Only the first differing bit decides; later bits are ignored.
                if (!found_q && diff_now) begin
                    found_d  = 1'b1;
                    sticky_d = bit_res;
                end
                scan_last = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
                scan_last = scan_last || diff_now;
`endif
                if (scan_last) begin
                    res_d       = found_d ? sticky_d : RES_EQ;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            found_q     <= 1'b0;
            sticky_q    <= RES_NONE;
            res_q       <= RES_NONE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            sticky_q    <= sticky_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign out_valid = out_valid_q;
    assign gt        = res_q.gt;
    assign eq        = res_q.eq;
    assign lt        = res_q.lt;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl: unsigned and signed instances driven in lockstep.
module tb_serial_cmp_ctrl;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;
    localparam logic [2:0] R_0  = 3'b000;

`ifdef CMP_EARLY_EXIT_EN
    localparam int N_B7 = 1;
    localparam int N_B3 = 5;
`else
    localparam int N_B7 = 8;
    localparam int N_B3 = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic in_ready_u, out_valid_u, gt_u, eq_u, lt_u, busy_u;
    logic in_ready_s, out_valid_s, gt_s, eq_s, lt_s, busy_s;
    logic [2:0] ru, rs;

    int checks   = 0;
    int failures = 0;

    assign ru = {gt_u, eq_u, lt_u};
    assign rs = {gt_s, eq_s, lt_s};

    always #5 clk = ~clk;

    serial_cmp_ctrl #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready),
        .gt(gt_u), .eq(eq_u), .lt(lt_u), .busy(busy_u)
    );

    serial_cmp_ctrl #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .gt(gt_s), .eq(eq_s), .lt(lt_s), .busy(busy_s)
    );

    task automatic run_job(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [2:0] exp_u, input logic [2:0] exp_s,
                           input int exp_n, input string name);
        int n;
        @(negedge clk);
        checks++;
        if (in_ready_u !== 1'b1 || busy_u !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: in_ready=%b busy=%b required in_ready=1 busy=0", name, in_ready_u, busy_u);
        end
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_v;
        checks++;
        if (busy_u !== 1'b1 || in_ready_u !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: busy=%b in_ready=%b required busy=1 in_ready=0", name, busy_u, in_ready_u);
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid_u !== 1'b1 && n < 20);
        checks++;
        if (out_valid_u !== 1'b1 || n != exp_n) begin
            failures++;
            $display("FAIL %s latency: out_valid=%b after %0d cycles required 1 after %0d", name, out_valid_u, n, exp_n);
        end
        checks++;
        if (out_valid_s !== 1'b1) begin
            failures++;
            $display("FAIL %s signed_valid: out_valid=%b required 1", name, out_valid_s);
        end
        checks++;
        if (ru !== exp_u) begin
            failures++;
            $display("FAIL %s unsigned_result: gt/eq/lt=%b required %b", name, ru, exp_u);
        end
        checks++;
        if (rs !== exp_s) begin
            failures++;
            $display("FAIL %s signed_result: gt/eq/lt=%b required %b", name, rs, exp_s);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0 1", name, out_valid_u, in_ready_u);
        end
        checks++;
        if (ru !== exp_u || rs !== exp_s) begin
            failures++;
            $display("FAIL %s hold: u=%b s=%b required u=%b s=%b", name, ru, rs, exp_u, exp_s);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        #3;
        checks++;
        if (in_ready_u !== 1'b1 || busy_u !== 1'b0 || out_valid_u !== 1'b0 || ru !== R_0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b res=%b required 1 0 0 000",
                     in_ready_u, busy_u, out_valid_u, ru);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        run_job(8'h5A, 8'h5A, R_EQ, R_EQ, 8, "equal_5a");
    endtask

    task automatic test_msb_diff();
        run_job(8'h80, 8'h7F, R_GT, R_LT, N_B7, "msb_80_7f");
        run_job(8'hFF, 8'h01, R_GT, R_LT, N_B7, "msb_ff_01");
    endtask

    task automatic test_lsb_diff();
        run_job(8'h04, 8'h05, R_LT, R_LT, 8, "lsb_04_05");
        run_job(8'h7F, 8'h7E, R_GT, R_GT, 8, "lsb_7f_7e");
    endtask

    task automatic test_mid_diff();
        run_job(8'h10, 8'h18, R_LT, R_LT, N_B3, "mid_10_18");
    endtask

    task automatic test_back_to_back();
        run_job(8'h00, 8'hFF, R_LT, R_GT, N_B7, "b2b_00_ff");
        run_job(8'hC3, 8'hC3, R_EQ, R_EQ, 8, "b2b_c3");
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h5A;
        b = 8'h5A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid_u !== 1'b1 && n < 20);
        checks++;
        if (out_valid_u !== 1'b1 || n != 8) begin
            failures++;
            $display("FAIL stall_latency: out_valid=%b after %0d cycles required 1 after 8", out_valid_u, n);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'(i * 37 + 1);
            b = 8'(~(i * 11));
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_u !== 1'b1 || ru !== R_EQ || rs !== R_EQ || in_ready_u !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out_valid=%b u=%b s=%b in_ready=%b required 1 010 010 0",
                         i, out_valid_u, ru, rs, in_ready_u);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || ru !== R_EQ) begin
            failures++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b res=%b required 1 0 010",
                     in_ready_u, out_valid_u, ru);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_u !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_accept: busy=%b required 0", busy_u);
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h5A;
        b = 8'h5A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_u !== 1'b0 || ru !== R_0 || busy_u !== 1'b0 || in_ready_u !== 1'b1 ||
            busy_s !== 1'b0 || in_ready_s !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_scan: out_valid=%b res=%b busy=%b in_ready=%b required 0 000 0 1",
                     out_valid_u, ru, busy_u, in_ready_u);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_job(8'h01, 8'h00, R_GT, R_GT, 8, "after_reset_01_00");
        rst_n = 1'b0;
        #1;
        checks++;
        if (ru !== R_0 || rs !== R_0) begin
            failures++;
            $display("FAIL reset_clears_result: u=%b s=%b required 000 000", ru, rs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_diff();
        test_lsb_diff();
        test_mid_diff();
        test_back_to_back();
        test_stall();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
